// File: rtl/ssd1306_pkg.sv
// ssd1306_pkg: shared FSM state type and SPI mode constants for the SSD1306 SPI transmitter
package ssd1306_pkg;
  typedef enum logic [2:0] {IDLE, SETUP, SCK_LO, SCK_HI, HOLD} spi_state_t;
  localparam logic [1:0] SPI_MODE = 2'd0;
  localparam logic SPI_CPOL = SPI_MODE[1];
endpackage

// File: rtl/ssd1306_spi_timer.sv
// ssd1306_spi_timer: reloadable 8-bit down-counter; done pulses in the last cycle of a loaded interval
module ssd1306_spi_timer (
  input  logic       clk_in,
  input  logic       reset_in,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic       done
);
  logic [7:0] cnt;
  always_ff @(posedge clk_in or posedge reset_in)
    if (reset_in) cnt <= '0;
    else cnt <= load ? load_val : (cnt != 8'd0) ? cnt - 8'd1 : cnt;
  assign done = cnt == 8'd1;
endmodule

// File: rtl/ssd1306_spi_tx.sv
// ssd1306_spi_tx: SPI mode 0 byte transmitter for the SSD1306 display.
// Define SSD1306_SPI_BURST_EN to keep CSn low across bytes accepted with last_byte_in=0.
module ssd1306_spi_tx #(
  parameter int CLK_DIV  = 2,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2
) (
  input  logic       clk_in,
  input  logic       reset_in,
  input  logic       tx_trigger_in,
  input  logic [7:0] data_in,
  input  logic       last_byte_in,
  output logic       ready_out,
  output logic       spi_sck_out,
  output logic       spi_mosi_out,
  output logic       spi_csn_out
);
  import ssd1306_pkg::*;
`ifdef SSD1306_SPI_BURST_EN
  localparam logic BURST = 1'b1;
`else
  localparam logic BURST = 1'b0;
`endif
  localparam logic [7:0] DIV_V = 8'(CLK_DIV);
  localparam logic [7:0] SETUP_V = 8'(CS_SETUP);
  localparam logic [7:0] HOLD_V = 8'(CS_HOLD);
  spi_state_t state, state_nxt;
  logic [7:0] sh, t_val;
  logic [2:0] bit_cnt;
  logic last_q, open_q, accept, t_load, t_done, bits_done, byte_end, chain_end, skip_setup;
  assign ready_out = state == IDLE;
  assign accept = tx_trigger_in && ready_out;
  assign bits_done = bit_cnt == 3'd7;
  assign byte_end = state == SCK_HI && t_done && bits_done;
  assign chain_end = !BURST || last_q;
  assign skip_setup = open_q || SETUP_V == 8'd0;
  assign spi_sck_out = SPI_CPOL ^ (state == SCK_HI);
  assign spi_mosi_out = sh[7];
  assign spi_csn_out = ready_out && !open_q;
  ssd1306_spi_timer u_timer (
    .clk_in   (clk_in),
    .reset_in (reset_in),
    .load     (t_load),
    .load_val (t_val),
    .done     (t_done)
  );
  always_comb begin
    state_nxt = state;
    t_load = 1'b0;
    t_val = DIV_V;
    case (state)
      IDLE: if (accept) begin
        state_nxt = skip_setup ? SCK_LO : SETUP;
        t_load = 1'b1;
        t_val = skip_setup ? DIV_V : SETUP_V;
      end
      SETUP: if (t_done) begin
        state_nxt = SCK_LO;
        t_load = 1'b1;
      end
      SCK_LO: if (t_done) begin
        state_nxt = SCK_HI;
        t_load = 1'b1;
      end
      SCK_HI: if (t_done) begin
        state_nxt = !bits_done ? SCK_LO : (!chain_end || HOLD_V == 8'd0) ? IDLE : HOLD;
        t_load = !bits_done || (chain_end && HOLD_V != 8'd0);
        t_val = bits_done ? HOLD_V : DIV_V;
      end
      HOLD: if (t_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end
  // MOSI is the shift register MSB, so it only moves at acceptance or on entry to SCK_LO
  always_ff @(posedge clk_in or posedge reset_in)
    if (reset_in) begin
      state <= IDLE;
      sh <= '0;
      bit_cnt <= '0;
      last_q <= 1'b0;
      open_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        sh <= data_in;
        bit_cnt <= '0;
        last_q <= last_byte_in;
      end else if (state == SCK_HI && t_done && !bits_done) begin
        sh <= {sh[6:0], 1'b0};
        bit_cnt <= bit_cnt + 3'd1;
      end
      if (byte_end) open_q <= !chain_end;
    end
endmodule

// File: tb/tb_ssd1306_spi_tx.sv
// tb_ssd1306_spi_tx: randomized bench for ssd1306_spi_tx (default and fast timing instances)
module tb_ssd1306_spi_tx;
`ifdef SSD1306_SPI_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif
  logic clk_in = 1'b0;
  logic reset_in = 1'b1;
  logic trig [2];
  logic lst [2];
  logic [7:0] din [2];
  logic rdy [2];
  logic sck [2];
  logic mosi [2];
  logic csn [2];
  bit open_st [2];
  int total = 0;
  int bad = 0;
  int viol = 0;

  ssd1306_spi_tx u_def (
    .clk_in        (clk_in),
    .reset_in      (reset_in),
    .tx_trigger_in (trig[0]),
    .data_in       (din[0]),
    .last_byte_in  (lst[0]),
    .ready_out     (rdy[0]),
    .spi_sck_out   (sck[0]),
    .spi_mosi_out  (mosi[0]),
    .spi_csn_out   (csn[0])
  );

  ssd1306_spi_tx #(.CLK_DIV(1), .CS_SETUP(0), .CS_HOLD(0)) u_fast (
    .clk_in        (clk_in),
    .reset_in      (reset_in),
    .tx_trigger_in (trig[1]),
    .data_in       (din[1]),
    .last_byte_in  (lst[1]),
    .ready_out     (rdy[1]),
    .spi_sck_out   (sck[1]),
    .spi_mosi_out  (mosi[1]),
    .spi_csn_out   (csn[1])
  );

  always #5 clk_in = ~clk_in;

  function automatic int div_of(input int u);
    return u == 1 ? 1 : 2;
  endfunction

  function automatic int setup_of(input int u);
    return u == 1 ? 0 : 2;
  endfunction

  function automatic int hold_of(input int u);
    return u == 1 ? 0 : 2;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Sends one byte and checks it against timing derived from the parameters.
  // The trigger is held for 'hold' cycles; abort_at>0 pulses reset after that many SCK rises.
  task automatic xfer(input int u, input logic [7:0] d, input logic l, input int hold, input int abort_at);
    int s_eff, h_eff, rises, first_rise, n;
    logic [7:0] got;
    logic psck, pmosi;
    bit done;
    s_eff = open_st[u] ? 0 : setup_of(u);
    h_eff = (BURST && !l) ? 0 : hold_of(u);
    n = 0;
    while (!rdy[u] && n < 2000) begin
      @(negedge clk_in);
      n++;
    end
    chk("ready_wait", rdy[u], 1);
    trig[u] = 1'b1;
    din[u] = d;
    lst[u] = l;
    psck = sck[u];
    pmosi = mosi[u];
    rises = 0;
    first_rise = 0;
    got = '0;
    done = 1'b0;
    for (n = 1; n <= 2000 && !done; n++) begin
      @(negedge clk_in);
      if (n == hold) trig[u] = 1'b0;
      if (trig[u]) begin
        din[u] = 8'($urandom);
        lst[u] = 1'($urandom);
      end
      if (n == 1) begin
        chk("csn_after_accept", csn[u], 0);
        chk("ready_after_accept", rdy[u], 0);
      end
      if (sck[u] && mosi[u] !== pmosi) viol++;
      if (sck[u] && !psck) begin
        rises++;
        got = {got[6:0], mosi[u]};
        if (rises == 1) first_rise = n;
      end
      if (abort_at != 0 && rises == abort_at) begin
        reset_in = 1'b1;
        trig[u] = 1'b0;
        #1;
        chk("rst_csn", csn[u], 1);
        chk("rst_sck", sck[u], 0);
        chk("rst_ready", rdy[u], 1);
        chk("rst_mosi", mosi[u], 0);
        @(negedge clk_in);
        reset_in = 1'b0;
        open_st[0] = 1'b0;
        open_st[1] = 1'b0;
        return;
      end
      if (rdy[u]) begin
        done = 1'b1;
        chk("byte_cycles", n, 1 + s_eff + 16 * div_of(u) + h_eff);
        chk("csn_end", csn[u], (BURST && !l) ? 0 : 1);
      end
      psck = sck[u];
      pmosi = mosi[u];
    end
    trig[u] = 1'b0;
    chk("done_seen", done, 1);
    chk("sck_rises", rises, 8);
    chk("first_rise", first_rise, 1 + s_eff + div_of(u));
    chk("mosi_byte", got, d);
    open_st[u] = BURST && !l;
  endtask

  initial begin
    int u;
    for (int i = 0; i < 2; i++) begin
      trig[i] = 1'b0;
      lst[i] = 1'b0;
      din[i] = '0;
      open_st[i] = 1'b0;
    end
    reset_in = 1'b1;
    repeat (3) @(negedge clk_in);
    for (int i = 0; i < 2; i++) begin
      chk("reset_ready", rdy[i], 1);
      chk("reset_csn", csn[i], 1);
      chk("reset_sck", sck[i], 0);
      chk("reset_mosi", mosi[i], 0);
    end
    reset_in = 1'b0;
    @(negedge clk_in);
    xfer(0, 8'hA5, 1'b1, 1, 0);
    xfer(0, 8'h5A, 1'b1, 10, 0);
    xfer(1, 8'hFF, 1'b1, 1, 0);
    xfer(0, 8'h12, 1'b0, 1, 0);
    xfer(0, 8'h34, 1'b1, 1, 0);
    xfer(0, 8'h3C, 1'b1, 1, 4);
    xfer(0, 8'hC3, 1'b1, 1, 0);
    repeat (40) begin
      u = int'($urandom_range(0, 1));
      xfer(u, 8'($urandom), 1'($urandom), int'($urandom_range(1, u == 1 ? 12 : 10)), 0);
      repeat ($urandom_range(0, 3)) @(negedge clk_in);
    end
    chk("mosi_stable_while_sck_high", viol, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
